alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_op_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and command layout for the ALU op sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_pkg;

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;

  localparam int HOLD_CYCLES_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // OP_IDLE is reserved for the sequencer itself, so it is never legal in a command.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_NOR);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of WIDTH bits, head presented as first-word-fall-through.
// Latency: a written entry becomes visible at the head one cycle after the write edge.
// Backpressure: full blocks pushes (no pass-through); push and pop in one cycle both apply.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             head_vld,
  output logic             occupied
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      wr_vis;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occupied = (wr_ptr != rd_ptr);
  // The read side only sees entries whose write edge has already passed one cycle ago.
  assign head_vld = (wr_vis != rd_ptr);
  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && head_vld;

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // Pointer bookkeeping, including the delayed write pointer seen by the read side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      wr_vis <= '0;
      rd_ptr <= '0;
    end else begin
      wr_vis <= wr_ptr;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands and holds each one on a bit-serial ALU for HOLD_CYCLES, then returns the result.
// Latency: command pushed at edge t into an idle, empty block gives res_valid from edge t+2+HOLD_CYCLES.
// Backpressure: cmd_ready drops when the FIFO is full; a result waits in RESP until res_ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [4:0] alu_c,
  input  logic       alu_zf,
  input  logic       alu_cf,
  input  logic       alu_sf,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [4:0] res_c,
  output logic       res_zf,
  output logic       res_cf,
  output logic       res_sf,
  output logic [2:0] res_op,
  output logic       err,
  output logic       busy
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    opa_q;
  logic [3:0]    opb_q;
  logic [2:0]    op_q;

  cmd_t          push_cmd;
  cmd_t          head;
  logic          fifo_full;
  logic          head_vld;
  logic          occupied;
  logic          fifo_pop;
  logic          load;
  logic          capture;
  logic          err_d;

  assign push_cmd = {cmd_a, cmd_b, cmd_op};

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_valid),
    .push_dat (push_cmd),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .head_dat (head),
    .head_vld (head_vld),
    .occupied (occupied)
  );

  assign cmd_ready  = !fifo_full;
  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  // The ALU only sees a live opcode while operands are being held.
  assign alu_opcode = (state_q == ST_ISSUE) ? op_q : OP_IDLE;
  assign res_valid  = (state_q == ST_RESP);
  assign err        = err_d;
  assign busy       = (state_q != ST_IDLE) || occupied;

  // Next-state and control strobes; illegal opcodes are dropped with a one-cycle err.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    capture  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_vld) begin
          fifo_pop = 1'b1;
          if (op_legal(head.op)) begin
            load    = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == LAST_CNT) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Hold counter: cleared on load, advances every ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt_q <= '0;
    else if (load)               cnt_q <= '0;
    else if (state_q == ST_ISSUE) cnt_q <= cnt_q + 1'b1;
  end

  // Operand registers; they keep their value after the operation finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa_q <= '0;
      opb_q <= '0;
      op_q  <= OP_IDLE;
    end else if (load) begin
      opa_q <= head.a;
      opb_q <= head.b;
      op_q  <= head.op;
    end
  end

  // Result registers, sampled from the ALU on the last hold cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_c  <= '0;
      res_zf <= 1'b0;
      res_cf <= 1'b0;
      res_sf <= 1'b0;
      res_op <= OP_IDLE;
    end else if (capture) begin
      res_c  <= alu_c;
      res_zf <= alu_zf;
      res_cf <= alu_cf;
      res_sf <= alu_sf;
      res_op <= op_q;
    end
  end

endmodule
